// File: rtl/fp_shifter_if.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | fp_shifter_if : operand/result bundle for the normalization stage |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
interface fp_shifter_if #(
   parameter int M = 10,
   parameter int E = 5
);
   logic [M-1:0] mantissa;
   logic         mantissa_overflow;
   logic [E-1:0] exp;
   logic [M-1:0] mant_shifted;
   logic [E-1:0] exp_shifted;

   modport master (
      output mantissa, mantissa_overflow, exp,
      input  mant_shifted, exp_shifted
   );

   modport slave (
      input  mantissa, mantissa_overflow, exp,
      output mant_shifted, exp_shifted
   );
endinterface
`default_nettype wire

// File: rtl/fp_shifter.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | fp_shifter : post-add normalization (carry, lz shift, clamp, inf) |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
module fp_shifter #(
   parameter int M = 10,
   parameter int E = 5
) (
   input  wire logic      clk,
   input  wire logic      reset,
   fp_shifter_if.slave    bus
);
   localparam int            LZW    = (M > 1) ? $clog2(M) : 1;
   localparam logic [E-1:0]  c_EMAX = '1;

   logic [LZW-1:0] w_lz;
   logic [LZW-1:0] w_shamt;
   logic [E:0]     w_exp_ext;
   logic [E:0]     w_lz_ext;
   logic [E:0]     w_exp_inc;
   logic [E:0]     w_exp_dec;
   logic           w_clamp;
   logic [M-1:0]   w_mant;
   logic [E-1:0]   w_exp;
   logic [M-1:0]   r_mant;
   logic [E-1:0]   r_exp;

   // Priority encoder: the highest set bit is visited last and wins.
   always_comb begin
      w_lz = LZW'(M - 1);
      for (int i = 0; i < M; i++) begin
         if (bus.mantissa[i]) w_lz = LZW'(M - 1 - i);
      end
   end

   assign w_exp_ext = {1'b0, bus.exp};
   assign w_lz_ext  = (E+1)'(w_lz);
   assign w_clamp   = (w_lz_ext > w_exp_ext);
   // When clamping, exp < lz <= M-1, so it fits the shift-amount width.
   assign w_shamt   = w_clamp ? LZW'(bus.exp) : w_lz;
   assign w_exp_inc = w_exp_ext + (E+1)'(1);
   assign w_exp_dec = w_clamp ? '0 : (w_exp_ext - w_lz_ext);

   always_comb begin
      w_mant = '0;
      w_exp  = '0;
      if (bus.exp == c_EMAX) begin
         w_mant = bus.mantissa;
         w_exp  = c_EMAX;
      end else if (bus.mantissa_overflow) begin
         if (w_exp_inc[E-1:0] == c_EMAX) begin
            w_mant = '0;
            w_exp  = c_EMAX;
         end else begin
            w_mant = {1'b1, bus.mantissa[M-1:1]};
            w_exp  = w_exp_inc[E-1:0];
         end
      end else if (bus.mantissa != '0) begin
         w_mant = bus.mantissa << w_shamt;
         w_exp  = w_exp_dec[E-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_mant <= '0;
         r_exp  <= '0;
      end else begin
         r_mant <= w_mant;
         r_exp  <= w_exp;
      end
   end

   assign bus.mant_shifted = r_mant;
   assign bus.exp_shifted  = r_exp;
endmodule
`default_nettype wire

// File: tb/tb_fp_shifter.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | tb_fp_shifter : randomized check against an arithmetic model      |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
module tb_fp_shifter;
   localparam int M    = 10;
   localparam int E    = 5;
   localparam int EMAX = (1 << E) - 1;

   logic clk;
   logic reset;
   int   n_total;
   int   n_bad;

   fp_shifter_if #(.M(M), .E(E)) bus ();

   fp_shifter #(.M(M), .E(E)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int expv);
      n_total++;
      if (obs != expv) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
      end
   endtask

   // Normalization described in plain arithmetic: bit length via log2.
   function automatic void model(input int m, input int ovf, input int e,
                                 output int rm, output int re);
      int lz, sh;
      if (e == EMAX) begin
         rm = m; re = EMAX;
      end else if (ovf != 0) begin
         re = e + 1;
         if (re == EMAX) rm = 0;
         else            rm = (m + (1 << M)) / 2;
      end else if (m == 0) begin
         rm = 0; re = 0;
      end else begin
         lz = M - $clog2(m + 1);
         sh = (lz <= e) ? lz : e;
         rm = (m * (1 << sh)) % (1 << M);
         re = e - sh;
      end
   endfunction

   task automatic apply(input string tag, input int m, input int ovf, input int e);
      int rm, re;
      bus.mantissa          = M'(m);
      bus.mantissa_overflow = ovf[0];
      bus.exp               = E'(e);
      if (reset) model(m, ovf, e, rm, re);
      else begin rm = 0; re = 0; end
      @(negedge clk);
      chk({tag, ".mant"}, int'(bus.mant_shifted), rm);
      chk({tag, ".exp"},  int'(bus.exp_shifted),  re);
   endtask

   initial begin
      int m, ovf, e;
      n_total = 0;
      n_bad   = 0;
      reset   = 1'b0;
      bus.mantissa          = M'($urandom);
      bus.mantissa_overflow = 1'b1;
      bus.exp               = E'(7);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst.mant", int'(bus.mant_shifted), 0);
      chk("rst.exp",  int'(bus.exp_shifted),  0);
      reset = 1'b1;

      apply("lz2",      'b0011100100, 0, 5);
      apply("lz2b",     'b0011100000, 0, 5);
      apply("ovf",      'b0011100100, 1, 25);
      apply("ovf_trunc",'b0010000001, 1, 25);
      apply("ovf_inf",  'b0011100100, 1, 30);
      apply("special",  'b0011100101, 1, 31);
      apply("spec_nov", 'b0000000011, 0, 31);
      apply("denorm",   'b0000010001, 0, 3);
      apply("ovf_zero", 0, 1, 0);
      apply("zero",     0, 0, 0);
      apply("one_e0",   1, 0, 0);
      apply("one_e9",   1, 0, 9);
      apply("msb_set",  'b1000000001, 0, 0);

      for (int i = 0; i < 400; i++) begin
         m   = $urandom_range(0, (1 << M) - 1);
         if ($urandom_range(0, 3) == 0) m = m >> $urandom_range(0, M);
         ovf = $urandom_range(0, 1);
         case ($urandom_range(0, 5))
            0:       e = EMAX;
            1:       e = EMAX - 1;
            2:       e = $urandom_range(0, 3);
            default: e = $urandom_range(0, EMAX);
         endcase
         if (i == 200) reset = 1'b0;
         if (i == 202) reset = 1'b1;
         apply("rand", m, ovf, e);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
